// File: rtl/axi_slave_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'b100;
  localparam int         BEAT_BYTES  = 16;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word-organised storage: byte-enabled synchronous write, asynchronous read.
// Latency: write visible after the clock edge; read is combinational.
// Backpressure: none, always accepts a write.
// Ports: clk; we/waddr/wdata/wstrb write port; raddr/rdata read port.
module axi_slave_mem_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_WORDS  = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by on-chip storage; one outstanding write and one read.
// Latency: first R beat the cycle after AR handshake; B the cycle after wlast.
// Backpressure: holds B/R stable while bready/rready low; AW/AR blocked while busy.
// Ports: clk, rst_n; AW/W/B write channels; AR/R read channels;
//        err_count = saturating count of SLVERR responses handed over on B and R.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 8,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [15:0]             err_count
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BEAT_BYTES);

  // Borrow bit of the subtraction flags addresses below the window.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && (64'(diff[ADDR_WIDTH-1:0] >> 4) < 64'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+3:4];
  endfunction

  // ---------------- write channel ----------------
  wstate_t               w_state, w_next;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic                  aw_err_q;   // burst type / size unsupported
  logic                  w_oor_q;    // an earlier beat fell outside storage
  logic [8:0]            w_cnt_q;    // beats accepted so far, saturating
  logic [1:0]            b_resp_q;
  logic                  aw_rdy_q, w_rdy_q, b_vld_q;
  logic                  aw_hs, w_hs, b_hs;
  logic                  w_beat_oor, w_final_err, mem_we;
  logic [IDX_W-1:0]      mem_widx;

  assign aw_hs = awvalid && aw_rdy_q;
  assign w_hs  = wvalid && w_rdy_q;
  assign b_hs  = b_vld_q && bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)          w_next = W_DATA;
      W_DATA:  if (w_hs && wlast)  w_next = W_RESP;
      W_RESP:  if (b_hs)           w_next = W_IDLE;
      default:                     w_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_beat_oor  = !in_range(aw_addr_q);
    mem_widx    = word_idx(aw_addr_q);
    // Beats past awlen+1 are acknowledged but never stored.
    mem_we      = w_hs && !w_beat_oor && (w_cnt_q <= {1'b0, aw_len_q});
    w_final_err = aw_err_q || w_oor_q || w_beat_oor || (w_cnt_q != {1'b0, aw_len_q});
  end

  // Handshake flags are registered from the next state so they stay low
  // through reset and rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_err_q  <= 1'b0;
      w_oor_q   <= 1'b0;
      w_cnt_q   <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      aw_rdy_q <= (w_next == W_IDLE);
      w_rdy_q  <= (w_next == W_DATA);
      b_vld_q  <= (w_next == W_RESP);
      if (aw_hs) begin
        aw_id_q   <= awid;
        aw_addr_q <= awaddr;
        aw_len_q  <= awlen;
        aw_err_q  <= (awburst != BURST_INCR) || (awsize != SIZE_16B);
        w_oor_q   <= 1'b0;
        w_cnt_q   <= '0;
      end
      if (w_hs) begin
        aw_addr_q <= aw_addr_q + BEAT_INC;
        if (w_cnt_q != '1) w_cnt_q <= w_cnt_q + 9'd1;
        if (w_beat_oor)    w_oor_q <= 1'b1;
        if (wlast)         b_resp_q <= w_final_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_next;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic                  ar_err_q;
  logic [7:0]            r_cnt_q;
  logic [DATA_WIDTH-1:0] r_dat_q;
  logic [1:0]            r_resp_q;
  logic                  r_last_q, ar_rdy_q, r_vld_q;
  logic                  ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_err_cfg, rd_oor;
  logic [IDX_W-1:0]      mem_ridx;
  logic [DATA_WIDTH-1:0] mem_rdata, rd_word;
  logic [1:0]            rd_resp;

  assign ar_hs = arvalid && ar_rdy_q;
  assign r_hs  = r_vld_q && rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)             r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_q)  r_next = R_IDLE;
      default:                        r_next = R_IDLE;
    endcase
  end

  // The read port looks ahead: beat 0 while idle, the following beat while
  // streaming, so the rdata register loads on the handshake edge.
  always_comb begin
    rd_addr    = (r_state == R_IDLE) ? araddr : (ar_addr_q + BEAT_INC);
    rd_err_cfg = (r_state == R_IDLE) ? ((arburst != BURST_INCR) || (arsize != SIZE_16B))
                                     : ar_err_q;
    rd_oor     = !in_range(rd_addr);
    mem_ridx   = word_idx(rd_addr);
    rd_word    = rd_oor ? '0 : mem_rdata;
    rd_resp    = (rd_oor || rd_err_cfg) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_rdy_q  <= 1'b0;
      r_vld_q   <= 1'b0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_err_q  <= 1'b0;
      r_cnt_q   <= '0;
      r_dat_q   <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      ar_rdy_q <= (r_next == R_IDLE);
      r_vld_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        ar_id_q   <= arid;
        ar_addr_q <= araddr;
        ar_len_q  <= arlen;
        ar_err_q  <= rd_err_cfg;
        r_cnt_q   <= '0;
        r_dat_q   <= rd_word;
        r_resp_q  <= rd_resp;
        r_last_q  <= (arlen == 8'd0);
      end else if (r_hs && !r_last_q) begin
        ar_addr_q <= rd_addr;
        r_cnt_q   <= r_cnt_q + 8'd1;
        r_dat_q   <= rd_word;
        r_resp_q  <= rd_resp;
        r_last_q  <= ((r_cnt_q + 8'd1) == ar_len_q);
      end else if (r_hs) begin
        r_last_q  <= 1'b0;
      end
    end
  end

  // ---------------- error counter ----------------
  logic [15:0] err_cnt_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    err_inc = 2'(b_hs && (b_resp_q == RESP_SLVERR)) + 2'(r_hs && (r_resp_q == RESP_SLVERR));
    err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  axi_slave_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_widx),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (mem_ridx),
    .rdata (mem_rdata)
  );

  assign awready   = aw_rdy_q;
  assign wready    = w_rdy_q;
  assign bvalid    = b_vld_q;
  assign bid       = aw_id_q;
  assign bresp     = b_resp_q;
  assign arready   = ar_rdy_q;
  assign rvalid    = r_vld_q;
  assign rid       = ar_id_q;
  assign rdata     = r_dat_q;
  assign rresp     = r_resp_q;
  assign rlast     = r_last_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 128, data bus width (bits); beat size 16 bytes.
REQ-002 Parameter ADDR_WIDTH, default 32, address width.
REQ-003 Parameter ID_WIDTH, default 8, AXI ID width.
REQ-004 Parameter MEM_WORDS, default 1024, storage depth in DATA_WIDTH words.
REQ-005 Parameter BASE_ADDR, default 32'h00000000, byte address of word 0.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 AW group: awid/awaddr/awlen(8)/awsize(3)/awburst(2)/awvalid  in; awready  out 1.
REQ-009 W group: wdata(DATA_WIDTH)/wstrb(DATA_WIDTH/8)/wlast/wvalid  in; wready  out 1.
REQ-010 B group: bid(ID_WIDTH)/bresp(2)/bvalid  out; bready  in 1.
REQ-011 AR group: arid/araddr/arlen(8)/arsize(3)/arburst(2)/arvalid  in; arready  out 1.
REQ-012 R group: rid/rdata/rresp(2)/rlast/rvalid  out; rready  in 1.
REQ-013 err_count  out  16  saturating count of SLVERR responses issued (B and R).

Function
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; both independent, one outstanding transaction each.
REQ-015 W_IDLE: awready=1; on awvalid&&awready latch awid, awaddr, awlen, error flag; go W_DATA.
REQ-016 W_DATA: wready=1; each wvalid&&wready writes wdata to word (addr-BASE_ADDR)>>4 under wstrb byte enables, then addr += 16, beat count += 1.
REQ-017 W_DATA exits to W_RESP on the beat with wlast=1.
REQ-018 W_RESP: bvalid=1, bid=latched awid; on bvalid&&bready return to W_IDLE; bid/bresp stable while bvalid&&!bready.
REQ-019 R_IDLE: arready=1; on arvalid&&arready latch arid, araddr, arlen, load rdata register with beat 0 word; go R_DATA.
REQ-020 R_DATA: rvalid=1 from cycle after AR handshake; rid=latched arid; rlast=1 when beat count equals arlen.
REQ-021 On rvalid&&rready with !rlast: addr += 16, rdata register loads next word; with rlast: return to R_IDLE.
REQ-022 rdata/rresp/rlast stable while rvalid&&!rready.
REQ-023 Word in range iff BASE_ADDR <= addr and ((addr-BASE_ADDR)>>4) < MEM_WORDS; out-of-range writes dropped, out-of-range reads return all-zero data.
REQ-024 bresp = 2'b10 (SLVERR) if any beat out of range, awburst != 2'b01, awsize != 3'b100, or wlast beat count != awlen+1; else 2'b00.
REQ-025 Beats beyond awlen+1 before wlast are accepted but not written.
REQ-026 rresp per beat = SLVERR if beat out of range, arburst != INCR or arsize != 3'b100; else OKAY.
REQ-027 Non-INCR bursts still advance the address by 16 per beat (treated as INCR).
REQ-028 Address wrap: addr increments modulo 2^ADDR_WIDTH; no 4 KB boundary check.
REQ-029 Same-edge write and rdata-register load of one word: load captures pre-write contents.
REQ-030 err_count increments once per B handshake with SLVERR and once per R handshake with SLVERR; holds at 16'hFFFF.

Reset
REQ-031 During reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata, err_count = 0; FSMs in W_IDLE/R_IDLE.
REQ-032 awready and arready are registered and rise on the first clock edge after rst_n deasserts.
REQ-033 Memory contents are not reset; reset mid-burst abandons the transaction with no response.

Structure
REQ-034 Package axi_slave_mem_pkg holds the RESP_OKAY/RESP_SLVERR constants, BURST_INCR, SIZE_16B and the write/read state enums.
REQ-035 Storage sits in sub-module axi_slave_mem_ram: one byte-enabled write port, one asynchronous read port, MEM_WORDS x DATA_WIDTH.

Verification
REQ-036 Single write awaddr=0x10, awlen=0, wdata=0xA5..A5, wstrb all 1 -> one wready beat, bresp=00, bid=awid; read araddr=0x10, arlen=0 -> rdata=0xA5..A5, rlast=1, rresp=00.
REQ-037 Burst write awaddr=0x0, awlen=8, data {4{addr}} per beat, then read arlen=8 -> nine beats match, rlast only on beat 9, err_count=0.
REQ-038 rready held low 5 cycles mid-burst -> rvalid, rdata, rlast unchanged throughout.
REQ-039 Write awaddr=BASE_ADDR+MEM_WORDS*16, awlen=0 -> bresp=10, err_count=1; readback returns 0 with rresp=10, err_count=2.
REQ-040 awlen=3 with wlast on beat 2 -> bresp=10, FSM returns W_IDLE after B handshake; subsequent AW accepted.
REQ-041 Assert rst_n low during R_DATA beat 2 -> rvalid=0 same cycle, arready=1 one edge after release.
